// File: rtl/key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// key_sched_ctrl
//
// Purpose:
//   Key schedule controller. Accepts a 16-bit master key over a valid/ready
//   handshake and expands it into NUM_ROUNDS+1 round keys, one per clock.
//   Each step applies a nibble S-box to choose a rotate amount, rotates,
//   substitutes the top nibble and XORs in the round number. The expanded
//   keys live in an internal table that the cipher datapath reads by index.
//   Reads are only serviced once the whole table is valid.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   key_valid   master key offered
//   key_in      master key value
//   key_ready   controller can accept a key (IDLE or READY)
//   rk_req      round-key read request
//   rk_idx      requested round-key index
//   rk_valid    one-cycle pulse, rk_out/rk_err valid
//   rk_out      requested round key (0 on error), holds when idle
//   rk_err      index beyond NUM_ROUNDS
//   busy        expansion in progress
//   keys_ready  complete key table available
// ---------------------------------------------------------------------------
module key_sched_ctrl #(
  parameter int NUM_ROUNDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [15:0] key_in,
  output logic        key_ready,
  input  logic        rk_req,
  input  logic [3:0]  rk_idx,
  output logic        rk_valid,
  output logic [15:0] rk_out,
  output logic        rk_err,
  output logic        busy,
  output logic        keys_ready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  localparam logic [3:0] LAST_IDX  = 4'(NUM_ROUNDS);
  localparam logic [3:0] LAST_STEP = 4'(NUM_ROUNDS - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_i;
  // Copy of rk[i] so the step logic never has to read the table.
  logic [15:0] r_cur;
  // Sized for the largest legal NUM_ROUNDS so rk_idx indexes it directly;
  // entries above NUM_ROUNDS stay zero and are never returned.
  logic [15:0] r_table [16];

  logic        r_rk_valid;
  logic [15:0] r_rk_out;
  logic        r_rk_err;

  logic        w_load;
  logic        w_rd;
  logic [3:0]  w_i_inc;
  logic [3:0]  w_sb_lo;
  logic [15:0] w_rot;
  logic [15:0] w_next;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // sel encodes a rotate-left amount of sel+1 (1..4).
  function automatic logic [15:0] rotl(input logic [15:0] x, input logic [1:0] sel);
    logic [15:0] y;
    case (sel)
      2'd0:    y = {x[14:0], x[15]};
      2'd1:    y = {x[13:0], x[15:14]};
      2'd2:    y = {x[12:0], x[15:13]};
      default: y = {x[11:0], x[15:12]};
    endcase
    return y;
  endfunction

  // key_ready depends on state only, never on key_valid.
  assign key_ready  = (r_state == ST_IDLE) || (r_state == ST_READY);
  assign busy       = (r_state == ST_EXPAND);
  assign keys_ready = (r_state == ST_READY);

  assign w_load = key_valid && key_ready;
  // Requests outside READY are dropped, not queued.
  assign w_rd   = rk_req && (r_state == ST_READY);

  assign w_i_inc = r_i + 4'd1;
  assign w_sb_lo = sbox(r_cur[3:0]);
  assign w_rot   = rotl(r_cur, w_sb_lo[1:0]);
  assign w_next  = {sbox(w_rot[15:12]), w_rot[11:0]} ^ {12'h000, w_i_inc};

  // Expansion FSM and key table.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_i     <= 4'd0;
      r_cur   <= 16'h0000;
      for (int k = 0; k < 16; k++) begin
        r_table[k] <= 16'h0000;
      end
    end else begin
      if (w_load) begin
        r_table[0] <= key_in;
        r_cur      <= key_in;
        r_i        <= 4'd0;
        r_state    <= ST_EXPAND;
      end else if (r_state == ST_EXPAND) begin
        r_table[w_i_inc] <= w_next;
        r_cur            <= w_next;
        if (r_i == LAST_STEP) begin
          r_state <= ST_READY;
        end else begin
          r_i <= w_i_inc;
        end
      end
    end
  end

  // Read port. A read that coincides with a load samples the table before
  // the load edge updates entry 0, so it sees the old key.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rk_valid <= 1'b0;
      r_rk_out   <= 16'h0000;
      r_rk_err   <= 1'b0;
    end else begin
      r_rk_valid <= w_rd;
      if (w_rd) begin
        if (rk_idx <= LAST_IDX) begin
          r_rk_out <= r_table[rk_idx];
          r_rk_err <= 1'b0;
        end else begin
          r_rk_out <= 16'h0000;
          r_rk_err <= 1'b1;
        end
      end
    end
  end

  assign rk_valid = r_rk_valid;
  assign rk_out   = r_rk_out;
  assign rk_err   = r_rk_err;

endmodule

// File: tb/tb_key_sched_ctrl.sv
module tb_key_sched_ctrl;

  localparam int NR = 8;
  localparam int NV = 8;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [15:0] key_in;
  logic        key_ready;
  logic        rk_req;
  logic [3:0]  rk_idx;
  logic        rk_valid;
  logic [15:0] rk_out;
  logic        rk_err;
  logic        busy;
  logic        keys_ready;

  key_sched_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .key_valid  (key_valid),
    .key_in     (key_in),
    .key_ready  (key_ready),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .rk_out     (rk_out),
    .rk_err     (rk_err),
    .busy       (busy),
    .keys_ready (keys_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] key;
    logic [3:0]  idx;
    logic [15:0] exp_out;
    logic        exp_err;
  } vec_t;
  vec_t vecs [NV];

  typedef struct {
    logic [15:0] out;
    logic        err;
    int unsigned due;
  } exp_t;
  exp_t sb [$];

  logic [3:0]  sbox_ref [16];
  logic [15:0] gold [16];
  logic [15:0] cur_key;
  logic        loaded;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] k, input int i);
    logic [15:0] t;
    logic [3:0]  s;
    int          amt;
    s   = sbox_ref[k[3:0]];
    amt = 1 + int'(s[1:0]);
    t   = k;
    for (int r = 0; r < amt; r++) t = {t[14:0], t[15]};
    t[15:12] = sbox_ref[t[15:12]];
    return t ^ {12'h000, 4'(i + 1)};
  endfunction

  task automatic fill_gold(input logic [15:0] k);
    gold[0] = k;
    for (int i = 0; i < 15; i++) begin
      gold[i+1] = (i < NR) ? model_step(gold[i], i) : 16'h0000;
    end
  endtask

  task automatic push_exp(input logic [15:0] o, input logic e);
    exp_t x;
    x.out = o;
    x.err = e;
    x.due = cyc + 1;
    sb.push_back(x);
  endtask

  // Scoreboard monitor: one line per response.
  always @(negedge clk) begin
    exp_t x;
    if (rk_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rk_valid", 1, 0);
      end else begin
        x = sb.pop_front();
        $display("rd cyc=%0d out=%04h err=%0d exp_out=%04h exp_err=%0d", cyc, rk_out, rk_err, x.out, x.err);
        chk("rk_out", rk_out, x.out);
        chk("rk_err", rk_err, x.err);
        chk("rk_latency", cyc, x.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      x = sb.pop_front();
      chk("missing_rk_valid", 0, 1);
    end
  end

  // Accept a key (waiting for key_ready) and wait out the expansion.
  task automatic load_key(input logic [15:0] k);
    int n;
    key_valid = 1'b1;
    key_in    = k;
    n = 0;
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("key_ready_wait", (n < 100), 1);
    @(negedge clk);
    key_valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    $display("load key=%04h busy_cycles=%0d", k, n);
    chk("busy_cycles", n, NR);
    chk("keys_ready_after_expand", keys_ready, 1);
    chk("key_ready_after_expand", key_ready, 1);
    cur_key = k;
    loaded  = 1'b1;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      rk_req = 1'b1;
      rk_idx = 4'(i);
      push_exp((i <= NR) ? gold[i] : 16'h0000, (i > NR));
      @(negedge clk);
    end
    rk_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [15:0] k1, k2;
    sbox_ref = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    rst_n = 1'b0; key_valid = 1'b0; key_in = 16'h0; rk_req = 1'b0; rk_idx = 4'h0;
    loaded = 1'b0; cur_key = 16'h0;

    fill_gold(16'h0000);
    vecs[0] = '{16'h0000, 4'd0,  16'h0000, 1'b0};
    vecs[1] = '{16'h0000, 4'd1,  16'hC001, 1'b0};
    vecs[2] = '{16'h0000, 4'd2,  16'hC005, 1'b0};
    vecs[3] = '{16'h0000, 4'd8,  gold[8],  1'b0};
    vecs[4] = '{16'h0000, 4'd9,  16'h0000, 1'b1};
    vecs[5] = '{16'h0000, 4'd15, 16'h0000, 1'b1};
    fill_gold(16'h1234);
    vecs[6] = '{16'h1234, 4'd0,  16'h1234, 1'b0};
    vecs[7] = '{16'h1234, 4'd1,  16'h98D1, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_keys_ready", keys_ready, 0);
    chk("rst_rk_valid", rk_valid, 0);
    chk("rst_rk_out", rk_out, 0);
    chk("rst_rk_err", rk_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors; same-key entries are read back-to-back.
    for (int v = 0; v < NV; v++) begin
      if (!loaded || vecs[v].key != cur_key) begin
        rk_req = 1'b0;
        @(negedge clk);
        load_key(vecs[v].key);
      end
      rk_req = 1'b1;
      rk_idx = vecs[v].idx;
      push_exp(vecs[v].exp_out, vecs[v].exp_err);
      @(negedge clk);
    end
    rk_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rk_out_hold", rk_out, 16'h98D1);
    chk("rk_valid_idle", rk_valid, 0);

    // rk_req during EXPAND is dropped.
    key_valid = 1'b1; key_in = 16'hBEEF;
    @(negedge clk);
    key_valid = 1'b0;
    rk_req = 1'b1; rk_idx = 4'd0;
    @(negedge clk);
    rk_req = 1'b0;
    chk("no_rk_valid_in_expand", rk_valid, 0);
    n = 0;
    while (!keys_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("expand_done_wait", (n < 100), 1);
    fill_gold(16'hBEEF);
    read_all();

    // Second key held during EXPAND; read coincides with its acceptance.
    k1 = 16'h5A3C; k2 = 16'h0F96;
    key_valid = 1'b1; key_in = k1;
    @(negedge clk);
    key_in = k2;
    n = 0;
    while (busy && n < 100) begin
      chk("key_ready_low_in_expand", key_ready, 0);
      n++;
      @(negedge clk);
    end
    chk("busy_cycles_k1", n, NR);
    chk("key_ready_on_ready", key_ready, 1);
    rk_req = 1'b1; rk_idx = 4'd0;
    push_exp(k1, 1'b0);
    @(negedge clk);
    key_valid = 1'b0; rk_req = 1'b0;
    chk("k2_accepted_busy", busy, 1);
    chk("k2_accepted_keys_ready", keys_ready, 0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles_k2", n, NR);
    cur_key = k2;
    fill_gold(k2);
    read_all();

    // Reset after 3 expansion steps.
    key_valid = 1'b1; key_in = 16'h7777;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_keys_ready", keys_ready, 0);
    chk("midrst_key_ready", key_ready, 1);
    chk("midrst_rk_out", rk_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rk_req = 1'b1; rk_idx = 4'd0;
    @(negedge clk);
    rk_req = 1'b0;
    chk("midrst_no_rk_valid", rk_valid, 0);
    chk("midrst_keys_ready_after", keys_ready, 0);
    chk("midrst_key_ready_after", key_ready, 1);
    load_key(16'h7777);
    fill_gold(16'h7777);
    read_all();

    // Random keys, full readback each.
    for (int r = 0; r < 100; r++) begin
      logic [15:0] k;
      k = 16'($urandom);
      load_key(k);
      fill_gold(k);
      read_all();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
